// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Holds the fetch state encoding, pipeline filler words and the PC step.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000D;
  localparam logic [31:0] PC_STEP           = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: valid/instr/pc/pc4 with bubble, load and hold.
// Bubble wins over load; with neither asserted the contents are held.
module if_id_reg
  import mips_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc4
);

  logic        valid_r;
  logic [31:0] instr_r;
  logic [31:0] pc_r;
  logic [31:0] pc4_r;

  // Register update: bubble clears, load captures, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      instr_r <= NOP_WORD;
      pc_r    <= 32'h0000_0000;
      pc4_r   <= 32'h0000_0000;
    end else if (bubble) begin
      valid_r <= 1'b0;
      instr_r <= NOP_WORD;
      pc_r    <= 32'h0000_0000;
      pc4_r   <= 32'h0000_0000;
    end else if (load) begin
      valid_r <= 1'b1;
      instr_r <= next_instr;
      pc_r    <= next_pc;
      pc4_r   <= next_pc + PC_STEP;
    end else begin
      valid_r <= valid_r;
      instr_r <= instr_r;
      pc_r    <= pc_r;
      pc4_r   <= pc4_r;
    end
  end

  assign valid = valid_r;
  assign instr = instr_r;
  assign pc    = pc_r;
  assign pc4   = pc4_r;

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, next-PC selection, BOOT/RUN/HALT control,
// out-of-range fault detection and retired-fetch counter feeding IF/ID.
module fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 8192,
  parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] WORD_LIMIT = 32'(IMEM_WORDS);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic         halted_r;
  logic         fault_r;
  logic [31:0]  count_r;
  logic         out_of_range_s;
  logic         load_s;
  logic         bubble_s;
  logic         unused_s;

  assign out_of_range_s = ({2'b00, pc_r[31:2]} >= WORD_LIMIT);
  assign unused_s       = ^redirect_pc[1:0];

  // IF/ID control derived from state and this cycle's inputs
  always_comb begin
    load_s   = 1'b0;
    bubble_s = 1'b0;
    case (state_r)
      BOOT: begin
        bubble_s = 1'b1;
      end
      RUN: begin
        bubble_s = redirect_valid | (~stall & out_of_range_s);
        load_s   = ~redirect_valid & ~stall & ~out_of_range_s;
      end
      HALT: begin
        bubble_s = redirect_valid | ~stall;
      end
      default: begin
        bubble_s = 1'b1;
      end
    endcase
  end

  // Fetch FSM with PC, halt/fault flags and retired-fetch counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= BOOT;
      pc_r     <= align_word(RESET_PC);
      halted_r <= 1'b0;
      fault_r  <= 1'b0;
      count_r  <= 32'd0;
    end else begin
      case (state_r)
        BOOT: begin
          if (redirect_valid) pc_r <= align_word(redirect_pc);
          state_r <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            pc_r <= align_word(redirect_pc);
          end else if (stall) begin
            pc_r <= pc_r;
          end else if (out_of_range_s) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
            fault_r  <= 1'b1;
          end else begin
            count_r <= count_r + 32'd1;
            // A captured break word parks the PC on itself
            if (imem_instr == HALT_WORD) begin
              state_r  <= HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pc_r + PC_STEP;
            end
          end
        end
        HALT: begin
          if (redirect_valid) begin
            pc_r     <= align_word(redirect_pc);
            state_r  <= RUN;
            halted_r <= 1'b0;
            fault_r  <= 1'b0;
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          state_r  <= BOOT;
          halted_r <= 1'b0;
          fault_r  <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_s),
    .bubble     (bubble_s),
    .next_instr (imem_instr),
    .next_pc    (pc_r),
    .valid      (ifid_valid),
    .instr      (ifid_instr),
    .pc         (ifid_pc),
    .pc4        (ifid_pc4)
  );

  assign imem_addr   = pc_r;
  assign halted      = halted_r;
  assign fetch_fault = fault_r;
  assign fetch_count = count_r;

endmodule
